ccff_bitstream_loader: RTL and testbench
========================================

Name: ccff_bitstream_loader

Overview:
- Upstream feeder of the configuration-chain (ccff) port of a logic tile or tile column.
- Accepts 32-bit bitstream words over a valid/ready handshake and serializes them MSB-first onto `ccff_head`, one bit per enabled `prog_clk` cycle.
- Drives the chain clock-enable consumed by an external ICG, so the chain shifts only while a valid bit is presented.
- Captures the bits leaving `ccff_tail` into readback words for integrity checking.

Parameters:
- `CHAIN_LEN`, 1024: total ccff bits in the downstream chain; range 1..65535.
- `WORD_W`, 32: bitstream/readback word width.
- `CNT_W`, $clog2(CHAIN_LEN+1): width of the shifted-bit counter (derived, not overridden).

Ports:
- `prog_clk`  in  1  programming clock.
- `pReset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse: begin a load; ignored unless state is IDLE or DONE.
- `abort`  in  1  one-cycle pulse: cancel the load, return to IDLE.
- `word_valid`  in  1  bitstream word offered.
- `word_data`  in  WORD_W  bitstream word; MSB shifted first.
- `word_ready`  out  1  loader accepts `word_data` this cycle.
- `ccff_head`  out  1  serial bit to the chain (registered).
- `cfg_clk_en`  out  1  chain clock enable (registered, aligned with `ccff_head`).
- `ccff_tail`  in  1  serial bit leaving the chain.
- `rb_valid`  out  1  one-cycle pulse: `rb_data` holds a readback word.
- `rb_data`  out  WORD_W  readback word; first-captured bit at MSB.
- `busy`  out  1  state is LOAD or DRAIN.
- `done`  out  1  high in DONE until the next `start` or `abort`.

Behaviour:
- Reset is asynchronous and active-low on `pReset`; the single clock is `prog_clk`.
- Reset values: all outputs 0, state IDLE, counters 0, buffers empty.
- States and transitions:
  - IDLE → LOAD on `start`.
  - LOAD → DRAIN when the bit counter reaches CHAIN_LEN.
  - DRAIN → DONE after the final partial readback word is emitted, or immediately if none remains.
  - DONE → LOAD on `start`.
  - Any state → IDLE on `abort`; `abort` beats a same-cycle `start`.
- Datapath is double-buffered: a WORD_W shift register plus a one-word holding register.
- `word_ready` = (state == LOAD) and holding register empty and words still needed, where words needed = ceil(CHAIN_LEN/WORD_W) minus words accepted.
- A word transfers when `word_valid` and `word_ready` are both high.
- The shift register reloads from the holding register in the same cycle its last bit issues, giving gapless streaming at 1 bit/cycle when words arrive in time.
- Emit cycle: state LOAD, shift register non-empty, count < CHAIN_LEN. On the emit edge, register `ccff_head` = shift MSB and `cfg_clk_en` = 1, shift left, count += 1.
- Otherwise `cfg_clk_en` = 0 and `ccff_head` holds its last value.
- Underrun (no bits available) stalls only: no error, no lost bits.
- Last word: only the top (CHAIN_LEN mod WORD_W) bits are used (all bits if the remainder is 0); the lower bits are discarded.
- Readback capture: on every edge where the registered `cfg_clk_en` is 1 (that is, the chain shifts), sample `ccff_tail` into the readback shift register LSB and shift up.
- Every WORD_W captures: `rb_data` updates and `rb_valid` pulses for one cycle.
- A final partial word is left-aligned, zero-filled, and emitted in DRAIN.
- Total readback bits = CHAIN_LEN. The first CHAIN_LEN captured bits are the chain's previous contents.
- Latency: `start` at edge N → first `cfg_clk_en` = 1 no earlier than edge N+2 (word accept, then emit).
- Counter never exceeds CHAIN_LEN; extra `word_valid` after the last word is not acknowledged.
- `abort` or reset mid-load:
  - `cfg_clk_en` = 0 from the next edge.
  - Counters and buffers cleared.
  - Partial readback discarded; no `rb_valid`.
  - Chain contents are left undefined.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LOAD, DRAIN, DONE);
  - WORD_W default;
  - the words-needed constant function.
- One natural sub-module: `ccff_rb_packer`, the serial-to-word readback packer with partial-word flush.

Test Plan:
- CHAIN_LEN=40, words 0xA5A5A5A5 and 0xFF000000, `word_valid` always high → exactly 40 `cfg_clk_en` pulses, contiguous. `ccff_head` sequence = A5A5A5A5 bits then 8 ones. `done` rises. The 24 low bits of word 2 are unused.
- Same load, chain model preloaded 0x123456789A → `rb_data` 0x12345678 then 0x9A000000, two `rb_valid` pulses.
- Second word delayed 5 cycles → `cfg_clk_en` low exactly 5 cycles after bit 32, no bit lost, total still 40.
- `abort` after 17 emitted bits → `cfg_clk_en` 0 next cycle, state IDLE, no `rb_valid`. A new `start` restarts at bit 0.
- `pReset` low mid-LOAD (asynchronous, between edges) → all outputs 0 immediately.
- `start` during LOAD → ignored.
- CHAIN_LEN=64, back-to-back loads via `start` in DONE → 64 pulses each, `done` deasserts on `start`.

Source files
------------

// File: rtl/ccff_bitstream_loader_pkg.sv
// Shared types and constants for the ccff bitstream loader and its readback packer.
package ccff_bitstream_loader_pkg;

  localparam int unsigned WORD_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  // Number of bitstream words required to fill a chain of chain_len bits.
  function automatic int unsigned words_needed(input int unsigned chain_len,
                                               input int unsigned word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// Serial-to-word readback packer: collects chain tail bits MSB-first into words,
// with a left-aligned, zero-filled flush of a final partial word.
module ccff_rb_packer
  import ccff_bitstream_loader_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              capture,
  input  logic              tail,
  input  logic              flush,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data,
  output logic              empty
);

  localparam int unsigned FILL_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] rb_shift;
  logic [WORD_W-1:0] rb_shift_next;
  logic [FILL_W-1:0] fill;

  // Next shift contents and empty flag.
  always_comb begin
    rb_shift_next = (rb_shift << 1) | WORD_W'(tail);
    empty         = (fill == '0);
  end

  // Capture one bit per chain shift; publish full words, flush partial word on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_shift <= '0;
      fill     <= '0;
      rb_valid <= 1'b0;
      rb_data  <= '0;
    end else if (clear) begin
      rb_shift <= '0;
      fill     <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (capture) begin
        if (fill == FILL_W'(WORD_W - 1)) begin
          rb_data  <= rb_shift_next;
          rb_valid <= 1'b1;
          rb_shift <= '0;
          fill     <= '0;
        end else begin
          rb_shift <= rb_shift_next;
          fill     <= fill + 1'b1;
        end
      end else if (flush && (fill != '0)) begin
        rb_data  <= rb_shift << (FILL_W'(WORD_W) - fill);
        rb_valid <= 1'b1;
        rb_shift <= '0;
        fill     <= '0;
      end
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain feeder: serializes bitstream words MSB-first onto ccff_head,
// drives the chain clock enable, and packs ccff_tail bits into readback words.
module ccff_bitstream_loader
  import ccff_bitstream_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 1024,
  parameter int unsigned WORD_W    = WORD_W_DEFAULT
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              cfg_clk_en,
  input  logic              ccff_tail,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W   = $clog2(CHAIN_LEN + 1);
  localparam int unsigned N_WORDS = words_needed(CHAIN_LEN, WORD_W);
  localparam int unsigned WCNT_W  = $clog2(N_WORDS + 1);
  localparam int unsigned SCNT_W  = $clog2(WORD_W + 1);

  state_t            state;
  state_t            state_next;
  logic [WORD_W-1:0] shift_reg;
  logic [SCNT_W-1:0] shift_cnt;
  logic [WORD_W-1:0] hold_reg;
  logic              hold_full;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WCNT_W-1:0] words_acc;
  logic              accept;
  logic              emit;
  logic              refill;
  logic              chain_full;
  logic              rb_empty;

  // Handshake, emit and refill qualifiers for the current cycle.
  always_comb begin
    chain_full = (bit_cnt == CNT_W'(CHAIN_LEN));
    emit       = (state == LOAD) && (shift_cnt != '0) && !chain_full && !abort;
    accept     = word_valid && word_ready;
    refill     = (shift_cnt == '0) || (emit && (shift_cnt == SCNT_W'(1)));
  end

  // State register.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic; abort overrides everything, including a same-cycle start.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (chain_full) state_next = DRAIN;
      DRAIN:   if (rb_empty) state_next = DONE;
      DONE:    if (start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // FSM-derived outputs.
  always_comb begin
    busy       = (state == LOAD) || (state == DRAIN);
    done       = (state == DONE);
    word_ready = (state == LOAD) && !hold_full && (words_acc < WCNT_W'(N_WORDS));
  end

  // Double-buffered datapath. When the shift register empties (or issues its last
  // bit) it is refilled from the holding register if occupied, else straight from an
  // accepted word, so an empty pipeline costs one accept edge before the first emit.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      shift_reg <= '0;
      shift_cnt <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      words_acc <= '0;
    end else if (state_next != LOAD) begin
      shift_reg <= '0;
      shift_cnt <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      words_acc <= '0;
    end else begin
      if (accept) words_acc <= words_acc + 1'b1;
      if (emit)   bit_cnt   <= bit_cnt + 1'b1;
      if (refill) begin
        if (hold_full) begin
          shift_reg <= hold_reg;
          shift_cnt <= SCNT_W'(WORD_W);
          hold_full <= 1'b0;
        end else if (accept) begin
          shift_reg <= word_data;
          shift_cnt <= SCNT_W'(WORD_W);
        end else begin
          shift_reg <= '0;
          shift_cnt <= '0;
        end
      end else begin
        if (emit) begin
          shift_reg <= shift_reg << 1;
          shift_cnt <= shift_cnt - 1'b1;
        end
        if (accept) begin
          hold_reg  <= word_data;
          hold_full <= 1'b1;
        end
      end
    end
  end

  // Registered chain outputs; ccff_head holds its value while the chain is stalled.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      ccff_head  <= 1'b0;
      cfg_clk_en <= 1'b0;
    end else begin
      cfg_clk_en <= emit;
      if (emit) ccff_head <= shift_reg[WORD_W-1];
    end
  end

  ccff_rb_packer #(
    .WORD_W(WORD_W)
  ) u_rb_packer (
    .clk     (prog_clk),
    .rst_n   (pReset),
    .clear   (abort),
    .capture (cfg_clk_en),
    .tail    (ccff_tail),
    .flush   (state == DRAIN),
    .rb_valid(rb_valid),
    .rb_data (rb_data),
    .empty   (rb_empty)
  );

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a 40-bit and a 64-bit chain instance, each fed
// by a behavioural chain model whose contents predict the readback words.
module tb_ccff_bitstream_loader;

  logic        clk    = 1'b0;
  logic        pReset = 1'b1;
  logic        start_s [2];
  logic        abort_s [2];
  logic        wv_s    [2];
  logic        wr_s    [2];
  logic [31:0] wd_s    [2];
  logic        head_s  [2];
  logic        en_s    [2];
  logic        tail_s  [2];
  logic        rbv_s   [2];
  logic [31:0] rbd_s   [2];
  logic        busy_s  [2];
  logic        done_s  [2];

  int unsigned clen [2] = '{40, 64};
  logic [63:0] chain_v [2];
  logic        en_prev [2];
  logic        head_prev [2];
  logic [31:0] wbuf [4];
  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned fails  = 0;

  always #5 clk = ~clk;

  ccff_bitstream_loader #(.CHAIN_LEN(40), .WORD_W(32)) dut40 (
    .prog_clk(clk), .pReset(pReset), .start(start_s[0]), .abort(abort_s[0]),
    .word_valid(wv_s[0]), .word_data(wd_s[0]), .word_ready(wr_s[0]),
    .ccff_head(head_s[0]), .cfg_clk_en(en_s[0]), .ccff_tail(tail_s[0]),
    .rb_valid(rbv_s[0]), .rb_data(rbd_s[0]), .busy(busy_s[0]), .done(done_s[0])
  );

  ccff_bitstream_loader #(.CHAIN_LEN(64), .WORD_W(32)) dut64 (
    .prog_clk(clk), .pReset(pReset), .start(start_s[1]), .abort(abort_s[1]),
    .word_valid(wv_s[1]), .word_data(wd_s[1]), .word_ready(wr_s[1]),
    .ccff_head(head_s[1]), .cfg_clk_en(en_s[1]), .ccff_tail(tail_s[1]),
    .rb_valid(rbv_s[1]), .rb_data(rbd_s[1]), .busy(busy_s[1]), .done(done_s[1])
  );

  function automatic logic [63:0] len_mask(input int unsigned n);
    return (n >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; a chain whose enable was registered high
  // shifted on the rising edge just passed, taking the head bit presented with it.
  task automatic tick();
    @(negedge clk);
    for (int unsigned d = 0; d < 2; d++) begin
      if (en_prev[d]) chain_v[d] = ((chain_v[d] << 1) | 64'(head_prev[d])) & len_mask(clen[d]);
      tail_s[d]    = chain_v[d][clen[d]-1];
      en_prev[d]   = en_s[d];
      head_prev[d] = head_s[d];
    end
  endtask

  // One load on instance d. delay2: cycles word 2 is withheld past its need point;
  // stall: random valid gaps; abort_at: abort after that many emitted bits (0 = none);
  // poke_start: extra start pulse mid-load.
  task automatic run_load(input int unsigned d, input int unsigned delay2, input bit stall,
                          input int unsigned abort_at, input bit poke_start);
    int unsigned nbits, nw, idx, pulses, last_en, gap, rbn, rb_exp_n, release_at;
    bit          acc, aborted, finished;
    bit          exp_head [$];
    logic [31:0] exp_rb [$];
    logic [31:0] w;
    logic [63:0] snap;
    nbits = clen[d];
    nw    = (nbits + 31) / 32;
    idx = 0; pulses = 0; last_en = 0; gap = 0; rbn = 0; release_at = 0;
    aborted = 1'b0; finished = 1'b0; w = '0;
    for (int unsigned i = 0; i < nbits; i++) exp_head.push_back(wbuf[i/32][31-(i%32)]);
    snap = chain_v[d];
    for (int unsigned i = 0; i < nbits; i++) begin
      w[31-(i%32)] = snap[nbits-1-i];
      if (((i % 32) == 31) || (i == nbits - 1)) begin
        exp_rb.push_back(w);
        w = '0;
      end
    end
    rb_exp_n = exp_rb.size();
    start_s[d] = 1'b1;
    tick();
    start_s[d] = 1'b0;
    chk("start_busy_done", {62'd0, busy_s[d], done_s[d]}, 64'b10);
    for (int unsigned cyc = 1; cyc <= 400; cyc++) begin
      wv_s[d] = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if ((delay2 != 0) && (idx == 1) && ((release_at == 0) || (cyc < release_at))) wv_s[d] = 1'b0;
      wd_s[d] = (idx < 4) ? wbuf[idx] : $urandom;
      if ((abort_at != 0) && (pulses == abort_at)) begin
        abort_s[d] = 1'b1;
        aborted    = 1'b1;
      end
      if (poke_start && (cyc == 10)) start_s[d] = 1'b1;
      acc = wv_s[d] && wr_s[d];
      tick();
      abort_s[d] = 1'b0;
      start_s[d] = 1'b0;
      if (acc) idx++;
      if (aborted) begin
        chk("abort_en_low", 64'(en_s[d]), 64'd0);
        chk("abort_idle", {61'd0, busy_s[d], done_s[d], wr_s[d]}, 64'd0);
        chk("abort_bits", 64'(pulses), 64'(abort_at));
        break;
      end
      if (en_s[d]) begin
        if (pulses == 0) chk("first_en_latency", 64'(cyc >= 2), 64'd1);
        else gap += cyc - last_en - 1;
        last_en = cyc;
        pulses++;
        if (exp_head.size() == 0) chk("extra_bit", 64'(pulses), 64'(nbits));
        else chk("head_bit", 64'(head_s[d]), 64'(exp_head.pop_front()));
        // Withheld word is accepted delay2 edges after the last bit of word 1
        // issued and emits on the following edge.
        if ((pulses == 32) && (delay2 != 0)) release_at = cyc + delay2;
      end
      if (rbv_s[d]) begin
        rbn++;
        if (exp_rb.size() == 0) chk("extra_rb", 64'(rbn), 64'(rb_exp_n));
        else chk("rb_word", 64'(rbd_s[d]), 64'(exp_rb.pop_front()));
      end
      if (done_s[d]) begin
        finished = 1'b1;
        break;
      end
    end
    wv_s[d] = 1'b0;
    if (!aborted) begin
      chk("done_seen", 64'(finished), 64'd1);
      chk("pulse_count", 64'(pulses), 64'(nbits));
      chk("words_accepted", 64'(idx), 64'(nw));
      chk("rb_count", 64'(rbn), 64'(rb_exp_n));
      if (!stall) chk("gap_cycles", 64'(gap), 64'(delay2));
    end
  endtask

  initial begin
    for (int unsigned d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; abort_s[d] = 1'b0; wv_s[d] = 1'b0; wd_s[d] = '0;
      en_prev[d] = 1'b0; head_prev[d] = 1'b0;
    end
    chain_v[0] = 64'h0000_0012_3456_789A;
    chain_v[1] = {$urandom, $urandom};
    tail_s[0]  = chain_v[0][39];
    tail_s[1]  = chain_v[1][63];
    #1 pReset = 1'b0;
    repeat (3) @(negedge clk);
    for (int unsigned d = 0; d < 2; d++) begin
      chk("reset_outputs", {58'd0, wr_s[d], head_s[d], en_s[d], rbv_s[d], busy_s[d], done_s[d]}, 64'd0);
      chk("reset_rb_data", 64'(rbd_s[d]), 64'd0);
    end
    pReset = 1'b1;
    tick();
    tick();

    // Directed 40-bit load: A5A5A5A5 then the top 8 bits of FF000000.
    wbuf[0] = 32'hA5A5_A5A5; wbuf[1] = 32'hFF00_0000; wbuf[2] = '0; wbuf[3] = '0;
    run_load(0, 0, 1'b0, 0, 1'b0);
    tick();
    // Second word arrives late: stall of exactly 5 cycles after bit 32.
    run_load(0, 5, 1'b0, 0, 1'b0);
    tick();
    // Abort after 17 emitted bits: no readback word may appear.
    run_load(0, 0, 1'b0, 17, 1'b0);
    repeat (4) begin
      tick();
      chk("no_rb_after_abort", 64'(rbv_s[0]), 64'd0);
    end
    // Fresh load restarts at bit 0; a start pulse mid-load is ignored.
    run_load(0, 0, 1'b0, 0, 1'b1);
    tick();

    // Asynchronous reset between edges in the middle of a load.
    start_s[0] = 1'b1; wv_s[0] = 1'b1; wd_s[0] = wbuf[0];
    tick();
    start_s[0] = 1'b0;
    repeat (6) tick();
    chk("mid_load_busy", 64'(busy_s[0]), 64'd1);
    #2 pReset = 1'b0;
    #1;
    chk("async_reset_outputs", {58'd0, wr_s[0], head_s[0], en_s[0], rbv_s[0], busy_s[0], done_s[0]}, 64'd0);
    chk("async_reset_rb_data", 64'(rbd_s[0]), 64'd0);
    en_prev[0] = 1'b0; en_prev[1] = 1'b0;
    @(negedge clk);
    pReset = 1'b1;
    wv_s[0] = 1'b0;
    tick();
    tick();

    // Back-to-back 64-bit loads from DONE; the second readback returns the first load.
    for (int k = 0; k < 2; k++) begin
      wbuf[0] = $urandom; wbuf[1] = $urandom;
      run_load(1, 0, 1'b0, 0, 1'b0);
    end
    tick();

    // Random words with random valid gaps on both chains.
    for (int k = 0; k < 3; k++) begin
      for (int unsigned j = 0; j < 4; j++) wbuf[j] = $urandom;
      run_load(0, 0, 1'b1, 0, 1'b0);
      tick();
      run_load(1, 0, 1'b1, 0, 1'b0);
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
